// File: rtl/expr_pkg.sv
// Shared constants and encodings for the streaming expression checker.
package expr_pkg;

  // ASCII characters the checker recognises
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_SLASH = 8'h2F;
  localparam logic [7:0] CH_LP    = 8'h28;
  localparam logic [7:0] CH_RP    = 8'h29;

  // Character classes after operator/paren enables are applied
  typedef enum logic [2:0] {
    CLS_DIG = 3'd0,
    CLS_OP  = 3'd1,
    CLS_LP  = 3'd2,
    CLS_RP  = 3'd3,
    CLS_BAD = 3'd4
  } cls_t;

  // Parser states: EMPTY = nothing seen, OPND = operand expected after op/'(',
  // NUM = last char a digit, CLOSE = last char ')', ERR = sticky failure
  typedef enum logic [2:0] {
    ST_EMPTY = 3'd0,
    ST_OPND  = 3'd1,
    ST_NUM   = 3'd2,
    ST_CLOSE = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

endpackage

// File: rtl/expr_char_class.sv
// Combinational classifier: ASCII char -> class code, honouring the operator
// enable mask and the parenthesis enable. Anything unrecognised or disabled is BAD.
module expr_char_class
  import expr_pkg::*;
#(
  parameter logic [3:0] OP_MASK  = 4'b1111,
  parameter int         PAREN_EN = 1
) (
  input  logic [7:0] ch,
  output cls_t       cls
);

  // Decode the char; OP_MASK bit order is {'/','*','-','+'}
  always_comb begin
    cls = CLS_BAD;
    if (ch >= CH_0 && ch <= CH_9) begin
      cls = CLS_DIG;
    end else begin
      case (ch)
        CH_PLUS:  if (OP_MASK[0]) cls = CLS_OP;
        CH_MINUS: if (OP_MASK[1]) cls = CLS_OP;
        CH_STAR:  if (OP_MASK[2]) cls = CLS_OP;
        CH_SLASH: if (OP_MASK[3]) cls = CLS_OP;
        CH_LP:    if (PAREN_EN != 0) cls = CLS_LP;
        CH_RP:    if (PAREN_EN != 0) cls = CLS_RP;
        default:  cls = CLS_BAD;
      endcase
    end
  end

endmodule

// File: rtl/expr_checker.sv
// Streaming syntax checker for ASCII arithmetic expressions.
// Input qualifier: a char is consumed on a rising edge where in_valid=1 and
// clr=0; there is no back-pressure, so every valid char is accepted. clr has
// priority and discards a simultaneous char.
// out/err/depth are registered: a char sampled at edge N shows after edge N.
module expr_checker
  import expr_pkg::*;
#(
  parameter int         MULTI_DIGIT = 1,
  parameter logic [3:0] OP_MASK     = 4'b1111,
  parameter int         PAREN_EN    = 1,
  parameter int         MAX_DEPTH   = 7,
  localparam int        DEPTH_W     = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               in_valid,
  input  logic [7:0]         in,
  output logic               out,
  output logic               err,
  output logic [DEPTH_W-1:0] depth
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_DEPTH);

  // Parser state register; kept as a named enum so it is visible by hierarchy
  state_t             state;
  state_t             nxt_state;
  logic [DEPTH_W-1:0] nxt_depth;
  cls_t               cls;

  expr_char_class #(
    .OP_MASK  (OP_MASK),
    .PAREN_EN (PAREN_EN)
  ) u_class (
    .ch  (in),
    .cls (cls)
  );

  // Next-state and depth update; over/underflow go to ERR with depth untouched
  always_comb begin
    nxt_state = state;
    nxt_depth = depth;
    if (in_valid) begin
      case (state)
        ST_EMPTY, ST_OPND: begin
          case (cls)
            CLS_DIG: nxt_state = ST_NUM;
            CLS_LP: begin
              if (depth == DEPTH_MAX) begin
                nxt_state = ST_ERR;
              end else begin
                nxt_state = ST_OPND;
                nxt_depth = depth + 1'b1;
              end
            end
            default: nxt_state = ST_ERR;
          endcase
        end
        ST_NUM: begin
          case (cls)
            CLS_DIG: nxt_state = (MULTI_DIGIT != 0) ? ST_NUM : ST_ERR;
            CLS_OP:  nxt_state = ST_OPND;
            CLS_RP: begin
              if (depth == '0) begin
                nxt_state = ST_ERR;
              end else begin
                nxt_state = ST_CLOSE;
                nxt_depth = depth - 1'b1;
              end
            end
            default: nxt_state = ST_ERR;
          endcase
        end
        ST_CLOSE: begin
          case (cls)
            CLS_OP: nxt_state = ST_OPND;
            CLS_RP: begin
              if (depth == '0) begin
                nxt_state = ST_ERR;
              end else begin
                nxt_state = ST_CLOSE;
                nxt_depth = depth - 1'b1;
              end
            end
            default: nxt_state = ST_ERR;
          endcase
        end
        default: nxt_state = ST_ERR;
      endcase
    end
  end

  // State, depth and registered output decode
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= ST_EMPTY;
      depth <= '0;
      out   <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= nxt_state;
      depth <= nxt_depth;
      out   <= ((nxt_state == ST_NUM) || (nxt_state == ST_CLOSE)) && (nxt_depth == '0);
      err   <= (nxt_state == ST_ERR);
    end
  end

endmodule

// File: tb/tb_expr_checker.sv
// Directed bench for expr_checker: four configurations share one input bus;
// each scenario starts with clr and checks only the instance it targets.
module tb_expr_checker;

  localparam int W = 4;

  logic       clk;
  logic       clr;
  logic       in_valid;
  logic [7:0] in;

  logic       out_def, err_def;
  logic [2:0] dep_def;
  logic       out_leg, err_leg;
  logic [2:0] dep_leg;
  logic       out_d2,  err_d2;
  logic [1:0] dep_d2;
  logic       out_msk, err_msk;
  logic [2:0] dep_msk;

  int vectors;
  int miscompares;

  logic [W-1:0] exp_q[$];

  expr_checker u_def (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
    .out(out_def), .err(err_def), .depth(dep_def)
  );

  expr_checker #(.MULTI_DIGIT(0), .PAREN_EN(0)) u_leg (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
    .out(out_leg), .err(err_leg), .depth(dep_leg)
  );

  expr_checker #(.MAX_DEPTH(2)) u_d2 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
    .out(out_d2), .err(err_d2), .depth(dep_d2)
  );

  expr_checker #(.OP_MASK(4'b0011)) u_msk (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
    .out(out_msk), .err(err_msk), .depth(dep_msk)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver: one char, outputs sampled 1 time unit after the capturing edge
  task automatic send_char(input logic [7:0] c);
    @(negedge clk);
    in_valid = 1'b1;
    in       = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in       = 8'h00;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  initial begin
    string s;
    logic [W-1:0] exp;
    vectors     = 0;
    miscompares = 0;
    clr      = 1'b0;
    in_valid = 1'b0;
    in       = 8'h00;

    // Reset state
    do_clr();
    check("rst_out",   {7'd0, out_def}, 8'd0);
    check("rst_err",   {7'd0, err_def}, 8'd0);
    check("rst_depth", {5'd0, dep_def}, 8'd0);

    // Legacy config: single digits, no parens
    send_str("2+3*8");
    check("leg_ok_out", {7'd0, out_leg}, 8'd1);
    check("leg_ok_err", {7'd0, err_leg}, 8'd0);
    do_clr();
    send_str("2+3");
    check("leg_pre_err", {7'd0, err_leg}, 8'd0);
    send_char("4");
    check("leg_2dig_err", {7'd0, err_leg}, 8'd1);
    check("leg_2dig_out", {7'd0, out_leg}, 8'd0);

    // Default config, per-char {depth, out} through the scoreboard queue
    do_clr();
    exp_q = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010,
              4'b0010, 4'b0010, 4'b0010, 4'b0001};
    s = "12*(3+45)";
    for (int i = 0; i < s.len(); i++) begin
      send_char(s[i]);
      exp = exp_q.pop_front();
      check($sformatf("expr12_%0d", i), {4'd0, dep_def, out_def}, {4'd0, exp});
    end
    check("expr12_err", {7'd0, err_def}, 8'd0);

    // Leading operator is sticky until clr
    do_clr();
    send_char("+");
    check("lead_op_err", {7'd0, err_def}, 8'd1);
    send_char("3");
    check("lead_hold_err", {7'd0, err_def}, 8'd1);
    check("lead_hold_out", {7'd0, out_def}, 8'd0);
    do_clr();
    check("clr_err", {7'd0, err_def}, 8'd0);
    send_char("7");
    check("after_clr_out", {7'd0, out_def}, 8'd1);
    check("after_clr_err", {7'd0, err_def}, 8'd0);

    // Underflow and bad char on default config
    do_clr();
    send_str("3)");
    check("under_err",   {7'd0, err_def}, 8'd1);
    check("under_depth", {5'd0, dep_def}, 8'd0);
    do_clr();
    send_str("1a");
    check("bad_char_err", {7'd0, err_def}, 8'd1);

    // Nesting limit of 2
    do_clr();
    send_char("(");
    check("nest_d1", {6'd0, dep_d2}, 8'd1);
    send_char("(");
    check("nest_d2", {6'd0, dep_d2}, 8'd2);
    check("nest_ok", {7'd0, err_d2}, 8'd0);
    send_char("(");
    check("nest_ovf_err",   {7'd0, err_d2}, 8'd1);
    check("nest_ovf_depth", {6'd0, dep_d2}, 8'd2);
    do_clr();
    send_char("1");
    check("d2_one_out", {7'd0, out_d2}, 8'd1);
    send_char(")");
    check("d2_rp_err", {7'd0, err_d2}, 8'd1);
    check("d2_rp_out", {7'd0, out_d2}, 8'd0);

    // Operator mask {'-','+'} only
    do_clr();
    send_char("6");
    check("msk_pre_err", {7'd0, err_msk}, 8'd0);
    send_char("*");
    check("msk_star_err", {7'd0, err_msk}, 8'd1);
    do_clr();
    send_str("6-2");
    check("msk_minus_out", {7'd0, out_msk}, 8'd1);
    check("msk_minus_err", {7'd0, err_msk}, 8'd0);

    // in_valid gaps hold state; in is ignored while invalid
    do_clr();
    send_char("5");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in = "+";
      @(posedge clk);
      #1;
      check($sformatf("gap_out_%0d", i), {7'd0, out_def}, 8'd1);
    end
    in = 8'h00;

    // clr beats a simultaneous char; state returns to EMPTY
    @(negedge clk);
    clr      = 1'b1;
    in_valid = 1'b1;
    in       = "9";
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    check("clr_win_out",   {7'd0, out_def}, 8'd0);
    check("clr_win_err",   {7'd0, err_def}, 8'd0);
    check("clr_win_depth", {5'd0, dep_def}, 8'd0);
    send_char("+");
    check("clr_win_empty", {7'd0, err_def}, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
